as_writeback_ext: RTL and testbench
===================================

# as_writeback_ext

Parametrised writeback stage with a registered MEM/WB boundary, a valid/ready handshake toward the memory stage, and a load-data return channel with byte-lane extraction and sign/zero extension. It accepts one retiring instruction per cycle, selects the result from ALU, load data, return address or immediate, and drives the register-file write port. Loads stall acceptance until the data memory signals read-valid. It replaces the purely combinational result mux at the end of the pipeline.

## Interface
- XLEN, 64, datapath and register width; legal values 32 and 64.
- IAW, 64, instruction-address width; `return_address_i` is zero-extended or truncated to XLEN.
- RAW, 5, register-address width.
- clk_i  in  1  clock, rising edge.
- rstn_i  in  1  reset; one clock, asynchronous assert, active-low.
- valid_i  in  1  upstream instruction valid.
- ready_o  out  1  stage can accept; reset 1.
- flush_i  in  1  synchronous kill of any pending load.
- reg_write_i  in  1  instruction writes rd.
- rd_addr_i  in  RAW  destination register.
- result_src_i  in  2  0 ALU, 1 load, 2 return address, 3 immediate.
- funct3_i  in  3  load size and sign (RV encoding).
- byte_off_i  in  log2(XLEN/8)  low address bits of the load.
- alu_result_i  in  XLEN  ALU result.
- imm_i  in  XLEN  immediate (LUI path).
- return_address_i  in  IAW  PC+4.
- dmem_rvalid_i  in  1  load data valid.
- dmem_rdata_i  in  XLEN  raw aligned memory word.
- rf_we_o  out  1  register-file write enable; reset 0.
- rf_waddr_o  out  RAW  write address; reset 0.
- rf_wdata_o  out  XLEN  write data; reset 0.
- retire_o  out  1  one-cycle pulse per completed instruction; reset 0.
- trap_o  out  1  misaligned-load pulse (macro only, otherwise tied 0); reset 0.

## Operation
- States: IDLE, WAIT_LD. Reset → IDLE.
- IDLE: ready_o=1. On valid_i: capture rd, reg_write, source, funct3, byte_off. Source ≠1 → result registered, stay IDLE. Source 1 → WAIT_LD.
- WAIT_LD: ready_o=0; valid_i ignored. On dmem_rvalid_i: extract, register, → IDLE. flush_i → IDLE, no write, no retire.
- dmem_rvalid_i in IDLE is ignored.
- Extraction: lane = byte_off aligned down to access size. funct3 000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU; signed forms sign-extend to XLEN, unsigned forms zero-extend. funct3 111, and 011/110 when XLEN=32, produce 0.
- rf_we_o = reg_write && rd≠0; rf_waddr_o/rf_wdata_o still update for rd=0. retire_o pulses for every completed instruction, including those with reg_write=0.
- rf_we_o and retire_o are single-cycle pulses; addr/data hold their last value.
- Asynchronous reset in WAIT_LD abandons the load; a later rvalid is ignored.

## Timing
- Non-load accepted in cycle N: rf_we_o/retire_o high in N+1; back-to-back throughput 1/cycle.
- Load accepted in N, rvalid in cycle M≥N+1: write in M+1; ready_o returns high in M+1.
- rvalid in the same cycle as acceptance is not sampled; the earliest load write is N+2.
- flush_i and rvalid in the same WAIT_LD cycle: flush wins.
- flush_i in IDLE has no effect; an accept in that cycle proceeds.
- No combinational path from inputs to any output except ready_o, which depends on state only.

## Configuration
- AS_WB_MISALIGN_TRAP_EN defined: a load whose byte_off is not a multiple of its size completes with rf_we_o=0 and retire_o=0, and trap_o pulses in the write cycle.
- Undefined: low offset bits are ignored (lane alignment above), the write proceeds, and trap_o is constant 0.

## Test plan
- Reset mid-WAIT_LD, then rvalid → ready_o=1 after reset, no rf_we_o, all outputs 0.
- Back-to-back ALU ops to x5=0x11, x6=0x22 in N, N+1 → rf_we_o in N+1 and N+2 with matching data; op to x0 → rf_we_o=0, retire_o=1.
- LB, off 3, rdata 0x0000_0000_8000_0000 (XLEN=64), rvalid 3 cycles after accept → ready_o low 3 cycles; wdata 0xFFFF_FFFF_FFFF_FF80 written 4 cycles after accept. LBU with the same inputs → wdata 0x80.
- LWU, off 4, rdata 0x8765_4321_0000_0000 → wdata 0x0000_0000_8765_4321; with XLEN=32, funct3 110 → wdata 0.
- flush_i in WAIT_LD together with rvalid → no write, no retire, ready_o=1 next cycle.
- LH at off 1: macro on → trap_o=1, rf_we_o=0; macro off → halfword from lane 0 written.

Source files
------------

// File: rtl/as_writeback_ext_if.sv
// MEM/WB boundary bundle for as_writeback_ext: retiring instruction, load-data return
// channel and register-file write port.
interface as_writeback_ext_if #(
  parameter int XLEN = 64,
  parameter int IAW  = 64,
  parameter int RAW  = 5
);
  localparam int OFFW = $clog2(XLEN / 8);

  logic            valid_i;
  logic            ready_o;
  logic            flush_i;
  logic            reg_write_i;
  logic [RAW-1:0]  rd_addr_i;
  logic [1:0]      result_src_i;
  logic [2:0]      funct3_i;
  logic [OFFW-1:0] byte_off_i;
  logic [XLEN-1:0] alu_result_i;
  logic [XLEN-1:0] imm_i;
  logic [IAW-1:0]  return_address_i;
  logic            dmem_rvalid_i;
  logic [XLEN-1:0] dmem_rdata_i;
  logic            rf_we_o;
  logic [RAW-1:0]  rf_waddr_o;
  logic [XLEN-1:0] rf_wdata_o;
  logic            retire_o;
  logic            trap_o;

  modport master (
    output valid_i, flush_i, reg_write_i, rd_addr_i, result_src_i, funct3_i, byte_off_i,
           alu_result_i, imm_i, return_address_i, dmem_rvalid_i, dmem_rdata_i,
    input  ready_o, rf_we_o, rf_waddr_o, rf_wdata_o, retire_o, trap_o
  );

  modport slave (
    input  valid_i, flush_i, reg_write_i, rd_addr_i, result_src_i, funct3_i, byte_off_i,
           alu_result_i, imm_i, return_address_i, dmem_rvalid_i, dmem_rdata_i,
    output ready_o, rf_we_o, rf_waddr_o, rf_wdata_o, retire_o, trap_o
  );
endinterface

// File: rtl/as_writeback_ext.sv
// Registered writeback stage: result mux, load byte-lane extraction and sign/zero extension.
// Define AS_WB_MISALIGN_TRAP_EN to turn misaligned loads into a trap pulse instead of a write.
module as_writeback_ext #(
  parameter int XLEN = 64,
  parameter int IAW  = 64,
  parameter int RAW  = 5
) (
  input logic          clk_i,
  input logic          rstn_i,
  as_writeback_ext_if.slave wb
);
  localparam int OFFW = $clog2(XLEN / 8);

  typedef enum logic {IDLE, WAIT_LD} state_t;

  state_t          state_q;
  logic [RAW-1:0]  rd_q;
  logic            rw_q;
  logic [2:0]      f3_q;
  logic [OFFW-1:0] off_q;
  logic            rf_we_q;
  logic            retire_q;
  logic [RAW-1:0]  waddr_q;
  logic [XLEN-1:0] wdata_q;

  logic [XLEN-1:0] res_d;
  logic [XLEN-1:0] ld_d;
  logic [OFFW-1:0] szmask;
  logic [OFFW-1:0] lane;
  logic [XLEN-1:0] sh;

  always_comb begin
    res_d = '0;
    case (wb.result_src_i)
      2'd0:    res_d = wb.alu_result_i;
      2'd2:    res_d = XLEN'(wb.return_address_i);
      2'd3:    res_d = wb.imm_i;
      default: res_d = '0;
    endcase
  end

  // Size mask from funct3[1:0]; the lane is the byte offset aligned down to the access size.
  always_comb begin
    szmask = '0;
    case (f3_q[1:0])
      2'b00:   szmask = '0;
      2'b01:   szmask = OFFW'(1);
      2'b10:   szmask = OFFW'(3);
      default: szmask = '1;
    endcase
    lane = off_q & ~szmask;
    sh   = wb.dmem_rdata_i >> {lane, 3'b000};
    ld_d = '0;
    case (f3_q)
      3'b000:  ld_d = XLEN'($signed(sh[7:0]));
      3'b001:  ld_d = XLEN'($signed(sh[15:0]));
      3'b010:  ld_d = XLEN'($signed(sh[31:0]));
      3'b011:  ld_d = (XLEN == 64) ? sh : '0;
      3'b100:  ld_d = XLEN'(sh[7:0]);
      3'b101:  ld_d = XLEN'(sh[15:0]);
      3'b110:  ld_d = (XLEN == 64) ? XLEN'(sh[31:0]) : '0;
      default: ld_d = '0;
    endcase
  end

`ifdef AS_WB_MISALIGN_TRAP_EN
  logic trap_q;
  logic misalign_d;
  assign misalign_d = |(off_q & szmask);
  assign wb.trap_o  = trap_q;
`else
  assign wb.trap_o  = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= IDLE;
      rd_q     <= '0;
      rw_q     <= 1'b0;
      f3_q     <= '0;
      off_q    <= '0;
      rf_we_q  <= 1'b0;
      retire_q <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
`ifdef AS_WB_MISALIGN_TRAP_EN
      trap_q   <= 1'b0;
`endif
    end else begin
      rf_we_q  <= 1'b0;
      retire_q <= 1'b0;
`ifdef AS_WB_MISALIGN_TRAP_EN
      trap_q   <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          // rvalid is never sampled here, including in the cycle a load is accepted.
          if (wb.valid_i) begin
            rd_q  <= wb.rd_addr_i;
            rw_q  <= wb.reg_write_i;
            f3_q  <= wb.funct3_i;
            off_q <= wb.byte_off_i;
            if (wb.result_src_i == 2'd1) begin
              state_q <= WAIT_LD;
            end else begin
              rf_we_q  <= wb.reg_write_i && (wb.rd_addr_i != '0);
              waddr_q  <= wb.rd_addr_i;
              wdata_q  <= res_d;
              retire_q <= 1'b1;
            end
          end
        end
        WAIT_LD: begin
          if (wb.flush_i) begin
            state_q <= IDLE;
          end else if (wb.dmem_rvalid_i) begin
            state_q <= IDLE;
`ifdef AS_WB_MISALIGN_TRAP_EN
            if (misalign_d) begin
              trap_q <= 1'b1;
            end else begin
              rf_we_q  <= rw_q && (rd_q != '0);
              waddr_q  <= rd_q;
              wdata_q  <= ld_d;
              retire_q <= 1'b1;
            end
`else
            rf_we_q  <= rw_q && (rd_q != '0);
            waddr_q  <= rd_q;
            wdata_q  <= ld_d;
            retire_q <= 1'b1;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wb.ready_o    = (state_q == IDLE);
  assign wb.rf_we_o    = rf_we_q;
  assign wb.rf_waddr_o = waddr_q;
  assign wb.rf_wdata_o = wdata_q;
  assign wb.retire_o   = retire_q;
endmodule

// File: tb/tb_as_writeback_ext.sv
// Bench for as_writeback_ext (XLEN=64, trap macro undefined): vector table plus scoreboard
// that checks every write/retire for data and exact cycle.
module tb_as_writeback_ext;
  localparam int XLEN = 64;
  localparam int IAW  = 64;
  localparam int RAW  = 5;

  logic clk_i  = 1'b0;
  logic rstn_i = 1'b0;
  always #5 clk_i = ~clk_i;

  as_writeback_ext_if #(.XLEN(XLEN), .IAW(IAW), .RAW(RAW)) wb();
  as_writeback_ext #(.XLEN(XLEN), .IAW(IAW), .RAW(RAW)) dut (
    .clk_i (clk_i),
    .rstn_i(rstn_i),
    .wb    (wb)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit trap_seen = 1'b0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    logic            we;
    logic [RAW-1:0]  addr;
    logic [XLEN-1:0] data;
    int              cyc;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    logic            rw;
    logic [RAW-1:0]  rd;
    logic [1:0]      src;
    logic [2:0]      f3;
    logic [2:0]      off;
    logic [XLEN-1:0] opnd;
    logic [XLEN-1:0] rdata;
    int              lat;
    logic            ewe;
    logic [XLEN-1:0] edata;
  } vec_t;
  vec_t tbl[14];

  function automatic vec_t mk(logic rw, logic [RAW-1:0] rd, logic [1:0] src, logic [2:0] f3,
                              logic [2:0] off, logic [XLEN-1:0] opnd, logic [XLEN-1:0] rdata,
                              int lat, logic ewe, logic [XLEN-1:0] edata);
    vec_t v;
    v.rw = rw; v.rd = rd; v.src = src; v.f3 = f3; v.off = off; v.opnd = opnd;
    v.rdata = rdata; v.lat = lat; v.ewe = ewe; v.edata = edata;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Every write/retire must match the head of the scoreboard, including its cycle.
  always @(negedge clk_i) begin
    exp_t e;
    if (rstn_i) begin
      if (wb.trap_o) trap_seen = 1'b1;
      if (wb.retire_o || wb.rf_we_o) begin
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write actual we=%b addr=%0d data=%h cyc=%0d required none",
                   wb.rf_we_o, wb.rf_waddr_o, wb.rf_wdata_o, cyc);
        end else begin
          e = sbq.pop_front();
          if (!(wb.retire_o === 1'b1 && wb.rf_we_o === e.we && wb.rf_waddr_o === e.addr &&
                wb.rf_wdata_o === e.data && cyc == e.cyc)) begin
            errors++;
            $display("FAIL wb_write actual ret=%b we=%b addr=%0d data=%h cyc=%0d required ret=1 we=%b addr=%0d data=%h cyc=%0d",
                     wb.retire_o, wb.rf_we_o, wb.rf_waddr_o, wb.rf_wdata_o, cyc,
                     e.we, e.addr, e.data, e.cyc);
          end
        end
      end
    end
  end

  // Issue one instruction; for loads, rvalid comes lat cycles after the accept cycle.
  // rvalid is also pulsed with junk in the accept cycle, which the DUT must ignore.
  task automatic drive_op(input vec_t v, input bit flush_on_rv);
    int n;
    int k;
    exp_t e;
    k = 0;
    while (!wb.ready_o && k < 20) begin tick(); k++; end
    check("ready_before_issue", 64'(wb.ready_o), 64'd1);
    wb.valid_i          = 1'b1;
    wb.reg_write_i      = v.rw;
    wb.rd_addr_i        = v.rd;
    wb.result_src_i     = v.src;
    wb.funct3_i         = v.f3;
    wb.byte_off_i       = v.off;
    wb.alu_result_i     = {$urandom, $urandom};
    wb.imm_i            = {$urandom, $urandom};
    wb.return_address_i = {$urandom, $urandom};
    wb.dmem_rvalid_i    = 1'b1;
    wb.dmem_rdata_i     = {$urandom, $urandom};
    case (v.src)
      2'd0: wb.alu_result_i     = v.opnd;
      2'd2: wb.return_address_i = v.opnd;
      2'd3: wb.imm_i            = v.opnd;
      default: ;
    endcase
    n = cyc;
    if (v.src != 2'd1) begin
      e.we = v.ewe; e.addr = v.rd; e.data = v.edata; e.cyc = n + 1;
      sbq.push_back(e);
    end
    tick();
    wb.valid_i       = 1'b0;
    wb.dmem_rvalid_i = 1'b0;
    if (v.src == 2'd1) begin
      while (cyc < n + v.lat) begin
        check("ready_low_wait", 64'(wb.ready_o), 64'd0);
        tick();
      end
      check("ready_low_rv", 64'(wb.ready_o), 64'd0);
      wb.dmem_rvalid_i = 1'b1;
      wb.dmem_rdata_i  = v.rdata;
      wb.flush_i       = flush_on_rv;
      if (!flush_on_rv) begin
        e.we = v.ewe; e.addr = v.rd; e.data = v.edata; e.cyc = cyc + 1;
        sbq.push_back(e);
      end
      tick();
      wb.dmem_rvalid_i = 1'b0;
      wb.flush_i       = 1'b0;
      wb.dmem_rdata_i  = {$urandom, $urandom};
      check("ready_after_load", 64'(wb.ready_o), 64'd1);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready"},  64'(wb.ready_o),    64'd1);
    check({tag, "_we"},     64'(wb.rf_we_o),    64'd0);
    check({tag, "_retire"}, 64'(wb.retire_o),   64'd0);
    check({tag, "_waddr"},  64'(wb.rf_waddr_o), 64'd0);
    check({tag, "_wdata"},  64'(wb.rf_wdata_o), 64'd0);
    check({tag, "_trap"},   64'(wb.trap_o),     64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = mk(1, 7,  0, 3'b000, 0, 64'hDEADBEEF12345678, 0, 0, 1, 64'hDEADBEEF12345678);
    tbl[1]  = mk(1, 1,  2, 3'b000, 0, 64'h0000000080000004, 0, 0, 1, 64'h0000000080000004);
    tbl[2]  = mk(1, 2,  3, 3'b000, 0, 64'hFFFFFFFFFFFFF000, 0, 0, 1, 64'hFFFFFFFFFFFFF000);
    tbl[3]  = mk(0, 3,  0, 3'b000, 0, 64'h55,               0, 0, 0, 64'h55);
    tbl[4]  = mk(1, 10, 1, 3'b000, 3, 0, 64'h0000000080000000, 3, 1, 64'hFFFFFFFFFFFFFF80);
    tbl[5]  = mk(1, 11, 1, 3'b100, 3, 0, 64'h0000000080000000, 3, 1, 64'h80);
    tbl[6]  = mk(1, 12, 1, 3'b110, 4, 0, 64'h8765432100000000, 1, 1, 64'h0000000087654321);
    tbl[7]  = mk(1, 13, 1, 3'b010, 4, 0, 64'h8765432100000000, 1, 1, 64'hFFFFFFFF87654321);
    tbl[8]  = mk(1, 14, 1, 3'b001, 1, 0, 64'h0000000012348001, 2, 1, 64'hFFFFFFFFFFFF8001);
    tbl[9]  = mk(1, 15, 1, 3'b101, 6, 0, 64'hABCD000000000000, 1, 1, 64'hABCD);
    tbl[10] = mk(1, 16, 1, 3'b011, 5, 0, 64'h0123456789ABCDEF, 2, 1, 64'h0123456789ABCDEF);
    tbl[11] = mk(1, 17, 1, 3'b111, 0, 0, 64'hFFFFFFFFFFFFFFFF, 1, 1, 64'h0);
    tbl[12] = mk(1, 18, 1, 3'b000, 7, 0, 64'h7F00000000000000, 1, 1, 64'h7F);
    tbl[13] = mk(1, 0,  1, 3'b100, 0, 0, 64'h0000000000000080, 1, 0, 64'h80);

    wb.valid_i = 0; wb.flush_i = 0; wb.reg_write_i = 0; wb.rd_addr_i = '0;
    wb.result_src_i = '0; wb.funct3_i = '0; wb.byte_off_i = '0; wb.alu_result_i = '0;
    wb.imm_i = '0; wb.return_address_i = '0; wb.dmem_rvalid_i = 0; wb.dmem_rdata_i = '0;

    repeat (2) tick();
    check_idle_outputs("reset");
    rstn_i = 1'b1;
    tick();

    // Back-to-back ALU results, then a write to x0 that retires without enabling the write.
    drive_op(mk(1, 5, 0, 3'b000, 0, 64'h11, 0, 0, 1, 64'h11), 1'b0);
    drive_op(mk(1, 6, 0, 3'b000, 0, 64'h22, 0, 0, 1, 64'h22), 1'b0);
    drive_op(mk(1, 0, 0, 3'b000, 0, 64'h33, 0, 0, 0, 64'h33), 1'b0);
    tick();

    for (int i = 0; i < 14; i++) begin
      drive_op(tbl[i], 1'b0);
      if (i % 3 == 0) tick();
    end
    repeat (2) tick();

    // flush together with rvalid: nothing retires, stage is ready again at once.
    drive_op(mk(1, 20, 1, 3'b000, 0, 0, 64'h12, 2, 1, 64'h12), 1'b1);
    check("flush_no_we", 64'(wb.rf_we_o), 64'd0);
    check("flush_no_retire", 64'(wb.retire_o), 64'd0);
    repeat (3) tick();

    // Reset while waiting on a load; the late rvalid must be ignored.
    wb.valid_i = 1'b1; wb.reg_write_i = 1'b1; wb.rd_addr_i = 5'd21;
    wb.result_src_i = 2'd1; wb.funct3_i = 3'b000; wb.byte_off_i = '0;
    tick();
    wb.valid_i = 1'b0;
    check("rst_wait_ready_low", 64'(wb.ready_o), 64'd0);
    rstn_i = 1'b0;
    #1;
    check_idle_outputs("rst_mid_load");
    #2;
    rstn_i = 1'b1;
    tick();
    wb.dmem_rvalid_i = 1'b1;
    wb.dmem_rdata_i  = 64'h5A;
    tick();
    wb.dmem_rvalid_i = 1'b0;
    check("post_rst_ready", 64'(wb.ready_o), 64'd1);
    check("post_rst_no_we", 64'(wb.rf_we_o), 64'd0);
    check("post_rst_no_retire", 64'(wb.retire_o), 64'd0);
    repeat (3) tick();

    check("scoreboard_drained", 64'(sbq.size()), 64'd0);
    check("trap_never", 64'(trap_seen), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
